// File: rtl/ub_read_sequencer_if.sv
// rtl/ub_read_sequencer_if.sv - command, unified-buffer read port and output stream bundle for ub_read_sequencer
//
// Optional macro: UB_READER_STRIDE_EN adds start_stride to the command group.
//
// Signals:
//   start, start_addr, row_count, [start_stride] : command from controller
//   busy, done                                   : command status
//   ub_addr, ub_en, ub_data                      : unified_buffer read port 0
//   out_data, out_valid, out_ready               : row stream to data setup
// Modports:
//   master : the sequencer side
//   slave  : the surrounding environment (controller, buffer, consumer)

interface ub_read_sequencer_if #(
    parameter int MATRIX_WIDTH = 14,
    parameter int COUNT_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 8
);
    logic                          start;
    logic [ADDR_WIDTH-1:0]         start_addr;
    logic [COUNT_WIDTH-1:0]        row_count;
`ifdef UB_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0]         start_stride;
`endif
    logic                          busy;
    logic                          done;
    logic [ADDR_WIDTH-1:0]         ub_addr;
    logic                          ub_en;
    logic [MATRIX_WIDTH-1:0][7:0]  ub_data;
    logic [MATRIX_WIDTH-1:0][7:0]  out_data;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        input  start, start_addr, row_count, ub_data, out_ready,
        output busy, done, ub_addr, ub_en, out_data, out_valid
`ifdef UB_READER_STRIDE_EN
        , input start_stride
`endif
    );

    modport slave (
        output start, start_addr, row_count, ub_data, out_ready,
        input  busy, done, ub_addr, ub_en, out_data, out_valid
`ifdef UB_READER_STRIDE_EN
        , output start_stride
`endif
    );
endinterface

// File: rtl/ub_read_sequencer.sv
// rtl/ub_read_sequencer.sv - credit-flow block reader from the unified buffer onto a valid/ready row stream
//
// Optional macro: UB_READER_STRIDE_EN (address step latched from start_stride;
// otherwise the step is 1).
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ub_read_sequencer_if.master (command, status, buffer read port, output stream)
//
// Rows are requested only while (in-flight reads + FIFO occupancy) < FIFO_DEPTH,
// so every returned row has a FIFO slot and backpressure never loses data.
// The FIFO head falls through combinationally, and a returning row is bypassed
// straight to the output when the FIFO is empty.

module ub_read_sequencer #(
    parameter int MATRIX_WIDTH = 14,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ub_read_sequencer_if.master    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int CRD_W = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                        state, state_next;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [ADDR_WIDTH-1:0]         stride;
    logic [COUNT_WIDTH-1:0]        remaining_q;
    logic [READ_LATENCY-1:0]       pipe_q;
    logic                          done_q;

    logic [MATRIX_WIDTH-1:0][7:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [OCC_W-1:0]              count_q;

    logic [CRD_W-1:0]              inflight;
    logic                          credit_ok;
    logic                          issue;
    logic                          tail;
    logic                          fifo_empty;
    logic                          push, pop;
    logic                          finish;
    logic                          accept_cmd;

`ifdef UB_READER_STRIDE_EN
    logic [ADDR_WIDTH-1:0]         stride_q;
    assign stride = stride_q;
`else
    assign stride = ADDR_WIDTH'(1);
`endif

    assign tail       = pipe_q[READ_LATENCY-1];
    assign fifo_empty = (count_q == '0);
    assign accept_cmd = (state == IDLE) && bus.start;

    // Credit check counts rows still inside the buffer pipeline plus rows parked in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + CRD_W'(pipe_q[i]);
        end
        credit_ok = (inflight + CRD_W'(count_q)) < CRD_W'(FIFO_DEPTH);
    end

    assign issue = (state == ISSUE) && credit_ok;

    // A returning row skips the FIFO only when nothing is queued ahead of it and it is taken now.
    assign pop  = !fifo_empty && bus.out_ready;
    assign push = tail && !(fifo_empty && bus.out_ready);

    assign finish = (state == DRAIN) && (pipe_q == '0) && fifo_empty;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = (bus.row_count == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (issue && (remaining_q == COUNT_WIDTH'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            pipe_q      <= '0;
            done_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
`ifdef UB_READER_STRIDE_EN
            stride_q    <= '0;
`endif
        end else begin
            state  <= state_next;
            done_q <= finish;
            pipe_q <= (pipe_q << 1) | READ_LATENCY'(issue);

            if (accept_cmd) begin
                addr_q      <= bus.start_addr;
                remaining_q <= bus.row_count;
`ifdef UB_READER_STRIDE_EN
                stride_q    <= bus.start_stride;
`endif
            end else if (issue) begin
                addr_q      <= addr_q + stride;
                remaining_q <= remaining_q - COUNT_WIDTH'(1);
            end

            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_q <= count_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    // Storage needs no reset: only entries covered by count_q are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.ub_data;
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.ub_en     = issue;
    assign bus.ub_addr   = addr_q;
    assign bus.out_valid = !fifo_empty || tail;
    assign bus.out_data  = !fifo_empty ? mem[rd_ptr] : (tail ? bus.ub_data : '0);

endmodule

// File: tb/tb_ub_read_sequencer.sv
// tb/tb_ub_read_sequencer.sv - self-checking bench for ub_read_sequencer

module tb_ub_read_sequencer;
    localparam int MW = 14;
    localparam int AW = 8;
    localparam int CW = 16;

    typedef logic [MW-1:0][7:0] row_t;

    typedef struct {
        string           name;
        logic [AW-1:0]   addr;
        logic [CW-1:0]   cnt;
        logic [AW-1:0]   stride;
        int              ready_mode;   // 0: always ready, 1: ready one cycle in four
        int              exp_busy;     // -1: not checked
        int              exp_done;     // cycle of done pulse, start cycle = 0; -1: not checked
        int              exp_gap;      // first out_valid minus first ub_en; -1: no output expected
        bit              exp_stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    row_t r1;

    ub_read_sequencer_if #(.MATRIX_WIDTH(MW), .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)) bus ();

    ub_read_sequencer #(
        .MATRIX_WIDTH(MW), .READ_LATENCY(2), .FIFO_DEPTH(4),
        .COUNT_WIDTH(CW), .ADDR_WIDTH(AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Row a, lane j holds a*j (mod 256).
    function automatic row_t row_of(input logic [AW-1:0] a);
        row_t r;
        for (int j = 0; j < MW; j++) begin
            r[j] = 8'(int'(a) * j);
        end
        return r;
    endfunction

    // Unified buffer model: address sampled at an edge, data on read_port two edges later.
    always @(posedge clk) begin
        r1          <= row_of(bus.ub_addr);
        bus.ub_data <= r1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"},      128'(bus.busy),      128'(0));
        check({tag, " done"},      128'(bus.done),      128'(0));
        check({tag, " ub_en"},     128'(bus.ub_en),     128'(0));
        check({tag, " ub_addr"},   128'(bus.ub_addr),   128'(0));
        check({tag, " out_valid"}, 128'(bus.out_valid), 128'(0));
        check({tag, " out_data"},  128'(bus.out_data),  128'(0));
    endtask

    task automatic run_vec(input vec_t v);
        int issued = 0;
        int acc = 0;
        int first_en = -1;
        int first_val = -1;
        int busy_n = 0;
        int done_n = 0;
        int done_c = -1;
        bit stall_seen = 0;
        bit exp_en;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus.start = (c == 0);
            if (c == 0) begin
                bus.start_addr = v.addr;
                bus.row_count  = v.cnt;
`ifdef UB_READER_STRIDE_EN
                bus.start_stride = v.stride;
`endif
            end
            bus.out_ready = (v.ready_mode == 0) ? 1'b1 : ((c % 4) == 0);
            #1;
            exp_en = (c >= 1) && (issued < int'(v.cnt)) && ((issued - acc) < 4) && (done_n == 0);
            if ((c >= 1) && (issued < int'(v.cnt)) && ((issued - acc) >= 4)) stall_seen = 1;
            check({v.name, " ub_en"}, 128'(bus.ub_en), 128'(exp_en));
            if (bus.ub_en) begin
                if (first_en < 0) first_en = c;
                check({v.name, " ub_addr"}, 128'(bus.ub_addr),
                      128'(AW'(v.addr + AW'(issued) * v.stride)));
                issued++;
            end
            if (bus.out_valid) begin
                if (first_val < 0) first_val = c;
                check({v.name, " out_data"}, 128'(bus.out_data),
                      128'(row_of(AW'(v.addr + AW'(acc) * v.stride))));
                if (bus.out_ready) acc++;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                done_c = c;
            end
            if ((done_n > 0) && (c >= done_c + 2)) break;
        end
        bus.start = 1'b0;
        check({v.name, " done seen before timeout"}, 128'(done_n > 0), 128'(1));
        check({v.name, " done pulses"}, 128'(done_n), 128'(1));
        check({v.name, " rows issued"}, 128'(issued), 128'(v.cnt));
        check({v.name, " rows accepted"}, 128'(acc), 128'(v.cnt));
        check({v.name, " stall seen"}, 128'(stall_seen), 128'(v.exp_stall));
        if (v.exp_busy >= 0) check({v.name, " busy cycles"}, 128'(busy_n), 128'(v.exp_busy));
        if (v.exp_done >= 0) check({v.name, " done cycle"}, 128'(done_c), 128'(v.exp_done));
        if (v.exp_gap >= 0) check({v.name, " first valid gap"}, 128'(first_val - first_en), 128'(v.exp_gap));
        else                check({v.name, " no output"}, 128'(first_val), 128'(-1));
    endtask

    initial begin
        vec_t vecs[$];
        vecs.push_back('{"blk16",   8'd0,   16'd16, 8'd1, 0, 19, 20,  2, 1'b0});
        vecs.push_back('{"blk16bp", 8'd0,   16'd16, 8'd1, 1, -1, -1,  2, 1'b1});
        vecs.push_back('{"zero",    8'd0,   16'd0,  8'd1, 0,  1,  2, -1, 1'b0});
        vecs.push_back('{"wrap",    8'd254, 16'd3,  8'd1, 0,  6,  7,  2, 1'b0});
        vecs.push_back('{"single",  8'd5,   16'd1,  8'd1, 0,  4,  5,  2, 1'b0});
`ifdef UB_READER_STRIDE_EN
        vecs.push_back('{"stride4", 8'd2,   16'd4,  8'd4, 0,  7,  8,  2, 1'b0});
`endif

        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.row_count  = '0;
`ifdef UB_READER_STRIDE_EN
        bus.start_stride = '0;
`endif
        bus.out_ready  = 1'b1;

        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            repeat (2) @(negedge clk);
        end

        // Asynchronous reset in the middle of ISSUE, after five reads have gone out.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.start_addr = 8'd0;
        bus.row_count  = 16'd16;
`ifdef UB_READER_STRIDE_EN
        bus.start_stride = 8'd1;
`endif
        bus.out_ready  = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        #1;
        check("midrst busy before reset", 128'(bus.busy), 128'(1));
        check("midrst valid before reset", 128'(bus.out_valid), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_vec('{"after_rst", 8'd40, 16'd4, 8'd1, 0, 7, 8, 2, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ub_read_sequencer.md
Name: ub_read_sequencer

Overview:
- Reader-side master for the unified buffer read port (addr0/en0/read_port0).
- On a start command, fetches a block of consecutive rows, absorbs the buffer's fixed read latency, and presents rows in order on a valid/ready stream toward the systolic data-setup stage.
- Credit-based flow control, so no returned row is ever dropped under backpressure.

Parameters:
- MATRIX_WIDTH, 14, bytes per row (byte_type lanes).
- READ_LATENCY, 2, cycles from en0/addr0 sample to valid read_port0; must equal the unified_buffer read latency.
- FIFO_DEPTH, 4, output FIFO entries; must be >= READ_LATENCY+1 (power of two).
- COUNT_WIDTH, 16, width of the row-count field.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  command strobe, one cycle.
- start_addr  in  buffer_addr_type  first row address.
- row_count  in  COUNT_WIDTH  number of rows to fetch.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when the last row has been accepted downstream.
- ub_addr  out  buffer_addr_type  to unified_buffer addr0.
- ub_en  out  1  to unified_buffer en0.
- ub_data  in  byte_type[MATRIX_WIDTH]  from unified_buffer read_port0.
- out_data  out  byte_type[MATRIX_WIDTH]  row to consumer.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Reset (async, any time, mid-command included):
  - busy=0, done=0, ub_en=0, ub_addr=0, out_valid=0, out_data=0.
  - FIFO flushed, latency pipe cleared, FSM to IDLE.
  - In-flight buffer reads are discarded.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - start=1 latches start_addr, row_count, and sets busy=1 next cycle.
  - If row_count=0: go directly to DRAIN, which completes immediately; done pulses in the 2nd cycle after start, and ub_en never asserts.
  - Otherwise go to ISSUE.
- ISSUE:
  - Each cycle, issue a read when credits are available: ub_en=1, ub_addr=current address.
  - Credits available means (in-flight reads + FIFO occupancy) < FIFO_DEPTH.
  - After each issue: address +1 (wraps modulo 2^address width), remaining count −1.
  - When no credit is available: ub_en=0 and ub_addr holds.
  - After the last issue, go to DRAIN.
- In-flight tracking:
  - A READ_LATENCY-deep valid shift register tracks reads.
  - When its tail is 1, ub_data is written into the FIFO.
  - Credits guarantee the FIFO is never full at that moment.
- DRAIN:
  - Wait until the pipe is empty and the FIFO is empty (last row accepted).
  - Then done=1 for one cycle, busy=0, return to IDLE.
- start while busy: ignored, no effect on state.
- Output stream:
  - out_data and out_valid come from the FIFO head (first-word fall-through).
  - out_data is held stable while out_valid && !out_ready.
  - Rows are emitted in address order.
- Simultaneous FIFO push and pop in one cycle: both occur, occupancy unchanged.
- Throughput: with out_ready held at 1, one row per cycle.
  - First out_valid appears READ_LATENCY cycles after the first ub_en.
  - busy spans row_count+READ_LATENCY+1 cycles.

Optional Feature:
- Macro UB_READER_STRIDE_EN.
- When defined: adds input start_stride (buffer_addr_type), latched on start; the address increments by start_stride per issue (wraps modulo 2^address width). Stride 0 re-reads the same row row_count times.
- When undefined: no port, stride is fixed at 1.

Test Plan:
- Reset, preload rows 0..15 with lane j = i*j; start_addr=0, row_count=16, out_ready=1 -> 16 rows out back-to-back, row i lane j = i*j, first out_valid READ_LATENCY cycles after first ub_en, a single done pulse.
- Same command with out_ready toggling 1 cycle on / 3 cycles off -> no row lost or duplicated; ub_en stalls once in-flight + FIFO reaches FIFO_DEPTH; out_data is stable while stalled.
- row_count=0 -> ub_en never asserts, done pulses in the 2nd cycle after start, out_valid stays 0.
- start_addr = max address − 1, row_count=3 -> reads at max−1, max, then 0; data matches.
- Assert rst mid-ISSUE after 5 rows -> all outputs 0 immediately (async); a new command afterwards completes correctly with no stale rows.
- UB_READER_STRIDE_EN defined, start_addr=2, stride=4, row_count=4 -> ub_addr sequence 2, 6, 10, 14; data matches.
